// File: rtl/part_select_pkg.sv
// Shared definitions for the part-select read-modify-write engine.
//   - request opcodes carried on req_op
//   - controller state encoding
package part_select_pkg;

  localparam logic [1:0] OP_WR_FULL  = 2'b00;
  localparam logic [1:0] OP_WR_FIELD = 2'b01;
  localparam logic [1:0] OP_RD_FIELD = 2'b10;
  localparam logic [1:0] OP_RSVD     = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    MERGE = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/field_mask_gen.sv
// Combinational field mask generator.
//   lo        : field LSB (physical bit index, 0 = register LSB)
//   len       : field width minus one
//   mask      : ones over bits lo .. lo+len, clipped to the register width
//   range_err : field extends past the register MSB (lo+len+1 > WIDTH)
// All arithmetic is done one bit wider than IDX_W so lo+len never wraps.
module field_mask_gen #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] lo,
  input  logic [IDX_W-1:0] len,
  output logic [WIDTH-1:0] mask,
  output logic             range_err
);

  logic [IDX_W:0] lo_ext;
  logic [IDX_W:0] hi;  // index of the field MSB

  assign lo_ext    = {1'b0, lo};
  assign hi        = lo_ext + {1'b0, len};
  // lo+len+1 > WIDTH is the same as hi >= WIDTH
  assign range_err = (hi >= (IDX_W+1)'(WIDTH));

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign mask[gi] = (lo_ext <= (IDX_W+1)'(gi)) && ((IDX_W+1)'(gi) <= hi);
    end
  endgenerate

endmodule

// File: rtl/part_select_rmw.sv
// Part-select register-file engine.
// Handles one request at a time through IDLE -> FETCH -> MERGE -> RESP:
// full-word writes, field writes with truncation of the source, and field
// reads with zero-extension. Each register carries a written bit so reads
// of never-written registers are flagged.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_op/addr/lo/len/data : request payload, latched on acceptance
//   resp_valid/resp_ready : response handshake, payload held until taken
//   resp_data/resp_err    : registered result and error flag
module part_select_rmw
  import part_select_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [IDX_W-1:0]  req_lo,
  input  logic [IDX_W-1:0]  req_len,
  input  logic [WIDTH-1:0]  req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_data,
  output logic              resp_err
);

  state_e state_reg, state_next;

  // latched request
  logic [1:0]        op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [IDX_W-1:0]  lo_reg;
  logic [IDX_W-1:0]  len_reg;
  logic [WIDTH-1:0]  data_reg;

  // values captured in FETCH
  logic [WIDTH-1:0]  old_reg;
  logic              old_written_reg;
  logic [WIDTH-1:0]  mask_reg;
  logic              range_err_reg;
  logic              addr_ok_reg;

  logic [WIDTH-1:0]  resp_data_reg;
  logic              resp_err_reg;

  // register bank as plain flops so it can be cleared by reset
  logic [WIDTH-1:0]  bank_reg [DEPTH];
  logic [DEPTH-1:0]  written_reg;

  logic [WIDTH-1:0]  mask;
  logic              range_err;

  field_mask_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_mask (
    .lo        (lo_reg),
    .len       (len_reg),
    .mask      (mask),
    .range_err (range_err)
  );

  // One-hot address decode; an address with no hit (>= DEPTH) reads zero
  // and is reported as an error in MERGE.
  logic [DEPTH-1:0]  addr_hit;
  logic [WIDTH-1:0]  rd_term [DEPTH];
  logic [WIDTH-1:0]  rd_data;
  logic              rd_written;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_decode
      assign addr_hit[gi] = (addr_reg == ADDR_W'(gi));
      assign rd_term[gi]  = addr_hit[gi] ? bank_reg[gi] : '0;
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_data = rd_data | rd_term[i];
    end
  end

  assign rd_written = |(addr_hit & written_reg);

  // MERGE datapath
  logic [WIDTH-1:0] old_eff;
  logic [WIDTH-1:0] merge_data;
  logic             merge_err;
  logic             merge_we;
  logic             bank_we;

  // never-written registers contribute zero old bits
  assign old_eff = old_written_reg ? old_reg : '0;

  always_comb begin
    merge_data = '0;
    merge_err  = 1'b1;
    merge_we   = 1'b0;
    if (addr_ok_reg) begin
      case (op_reg)
        OP_WR_FULL: begin
          merge_data = data_reg;
          merge_err  = 1'b0;
          merge_we   = 1'b1;
        end
        OP_WR_FIELD: begin
          if (range_err_reg) begin
            merge_data = old_eff;
            merge_err  = 1'b1;
          end else begin
            merge_data = (old_eff & ~mask_reg) | ((data_reg << lo_reg) & mask_reg);
            merge_err  = 1'b0;
            merge_we   = 1'b1;
          end
        end
        OP_RD_FIELD: begin
          merge_data = (old_eff & mask_reg) >> lo_reg;
          merge_err  = range_err_reg | ~old_written_reg;
        end
        default: begin
          merge_data = '0;
          merge_err  = 1'b1;
        end
      endcase
    end
  end

  assign bank_we = (state_reg == MERGE) && merge_we;

  // next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = FETCH;
      FETCH:   state_next = MERGE;
      MERGE:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      op_reg          <= '0;
      addr_reg        <= '0;
      lo_reg          <= '0;
      len_reg         <= '0;
      data_reg        <= '0;
      old_reg         <= '0;
      old_written_reg <= 1'b0;
      mask_reg        <= '0;
      range_err_reg   <= 1'b0;
      addr_ok_reg     <= 1'b0;
      resp_data_reg   <= '0;
      resp_err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg   <= req_op;
            addr_reg <= req_addr;
            lo_reg   <= req_lo;
            len_reg  <= req_len;
            data_reg <= req_data;
          end
        end
        FETCH: begin
          old_reg         <= rd_data;
          old_written_reg <= rd_written;
          mask_reg        <= mask;
          range_err_reg   <= range_err;
          addr_ok_reg     <= |addr_hit;
        end
        MERGE: begin
          resp_data_reg <= merge_data;
          resp_err_reg  <= merge_err;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_reg[i] <= '0;
      end
      written_reg <= '0;
    end else if (bank_we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_hit[i]) begin
          bank_reg[i]    <= merge_data;
          written_reg[i] <= 1'b1;
        end
      end
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_data  = resp_data_reg;
  assign resp_err   = resp_err_reg;

endmodule
